inst_fetch: RTL and testbench

Instruction fetch unit: the producer side of the IF→instruction-queue interface. It holds the fetch PC, gets 32-bit instruction words from the memory controller (optionally through a direct-mapped I-cache), and pushes `{inst, PC}` pairs into the instruction queue. It obeys the queue's registered full flag and restarts from a new PC on a pipeline roll.

---
 rtl/inst_fetch_pkg.sv | 22 ++
 rtl/inst_fetch_icache.sv | 59 +++++
 rtl/inst_fetch.sv | 154 +++++++++++++++
 tb/tb_inst_fetch.sv | 508 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// ICACHE_EN (macro) compiles in the direct-mapped I-cache.
package inst_fetch_pkg;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    localparam int ICACHE_IDX_W_DEF = 6;

    typedef enum logic [1:0] {
        IF_IDLE = 2'd0,
        IF_WAIT = 2'd1,
        IF_DROP = 2'd2
    } if_state_e;

    function automatic logic [31:0] pc_next(
        input logic [31:0] pc
    );
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/inst_fetch_icache.sv
// Direct-mapped, one-word-per-line instruction cache.
// Only present when ICACHE_EN is defined.
`ifdef ICACHE_EN
module inst_fetch_icache
    import inst_fetch_pkg::*;
#(
    parameter int IDX_W = ICACHE_IDX_W_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    output logic        hit,
    output logic [31:0] data,
    input  logic        fill_en,
    input  logic [31:0] fill_addr,
    input  logic [31:0] fill_data
);

    localparam int LINES = 1 << IDX_W;
    localparam int TAG_W = 30 - IDX_W;

    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [31:0]      data_q [LINES];

    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] wr_idx;
    logic [TAG_W-1:0] rd_tag;
    logic [TAG_W-1:0] wr_tag;
    logic             unused_lsb;

    assign rd_idx = addr[IDX_W+1:2];
    assign rd_tag = addr[31:IDX_W+2];
    assign wr_idx = fill_addr[IDX_W+1:2];
    assign wr_tag = fill_addr[31:IDX_W+2];
    assign unused_lsb = ^{addr[1:0], fill_addr[1:0]};

    assign hit  = valid_q[rd_idx]
               && (tag_q[rd_idx] == rd_tag);
    assign data = data_q[rd_idx];

    // Only the valid bits need clearing; stale tags are masked by them.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (fill_en) begin
            valid_q[wr_idx] <= TRUE;
        end
    end

    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_q[wr_idx]  <= wr_tag;
            data_q[wr_idx] <= fill_data;
        end
    end

endmodule
`endif

// File: rtl/inst_fetch.sv
// Instruction fetch: PC, memory request FSM, push into the IQ.
// Define ICACHE_EN to place an I-cache in front of memory.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int ICACHE_IDX_W = ICACHE_IDX_W_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        roll,
    input  logic [31:0] roll_PC,
    input  logic        IQ_full,
    output logic        IF_flag,
    output logic [31:0] IF_inst,
    output logic [31:0] IF_PC,
    output logic        Mem_req,
    output logic [31:0] Mem_addr,
    input  logic        Mem_done,
    input  logic [31:0] Mem_inst
);

    if_state_e   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        flag_q, flag_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] ifpc_q, ifpc_d;
    logic        req_q, req_d;
    logic [31:0] addr_q, addr_d;

    logic        hit;
    logic [31:0] hit_data;

    assign IF_flag  = flag_q;
    assign IF_inst  = inst_q;
    assign IF_PC    = ifpc_q;
    assign Mem_req  = req_q;
    assign Mem_addr = addr_q;

`ifdef ICACHE_EN
    logic fill_en;

    assign fill_en = rdy && !roll && Mem_done
                  && (state_q == IF_WAIT);

    inst_fetch_icache #(
        .IDX_W     (ICACHE_IDX_W)
    ) u_icache (
        .clk       (clk),
        .rst       (rst),
        .addr      (pc_q),
        .hit       (hit),
        .data      (hit_data),
        .fill_en   (fill_en),
        .fill_addr (pc_q),
        .fill_data (Mem_inst)
    );
`else
    logic unused_cfg;

    assign unused_cfg = |ICACHE_IDX_W;
    assign hit        = FALSE;
    assign hit_data   = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IF_IDLE;
            pc_q    <= '0;
            flag_q  <= FALSE;
            inst_q  <= '0;
            ifpc_q  <= '0;
            req_q   <= FALSE;
            addr_q  <= '0;
        end else if (rdy) begin
            state_q <= state_d;
            pc_q    <= pc_d;
            flag_q  <= flag_d;
            inst_q  <= inst_d;
            ifpc_q  <= ifpc_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        flag_d  = FALSE;
        inst_d  = inst_q;
        ifpc_d  = ifpc_q;
        req_d   = req_q;
        addr_d  = addr_q;

        if (roll) begin
            // The controller needs req held until done, hence DROP.
            pc_d = roll_PC;
            unique case (state_q)
                IF_IDLE: state_d = IF_IDLE;
                IF_WAIT: begin
                    if (Mem_done) begin
                        req_d   = FALSE;
                        state_d = IF_IDLE;
                    end else begin
                        state_d = IF_DROP;
                    end
                end
                IF_DROP: begin
                    if (Mem_done) begin
                        req_d   = FALSE;
                        state_d = IF_IDLE;
                    end
                end
                default: state_d = IF_IDLE;
            endcase
        end else begin
            unique case (state_q)
                IF_IDLE: begin
                    // flag_q marks a push IQ_full cannot see yet.
                    if (!IQ_full && !flag_q) begin
                        if (hit) begin
                            flag_d = TRUE;
                            inst_d = hit_data;
                            ifpc_d = pc_q;
                            pc_d   = pc_next(pc_q);
                        end else begin
                            req_d   = TRUE;
                            addr_d  = pc_q;
                            state_d = IF_WAIT;
                        end
                    end
                end
                IF_WAIT: begin
                    if (Mem_done) begin
                        req_d   = FALSE;
                        flag_d  = TRUE;
                        inst_d  = Mem_inst;
                        ifpc_d  = pc_q;
                        pc_d    = pc_next(pc_q);
                        state_d = IF_IDLE;
                    end
                end
                IF_DROP: begin
                    if (Mem_done) begin
                        req_d   = FALSE;
                        state_d = IF_IDLE;
                    end
                end
                default: state_d = IF_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed scenarios plus a
// randomized run against a stream/queue reference model.
`timescale 1ns/1ps
module tb_inst_fetch;

    localparam int CAP = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        roll;
    logic [31:0] roll_PC;
    logic        IQ_full;
    logic        IF_flag;
    logic [31:0] IF_inst;
    logic [31:0] IF_PC;
    logic        Mem_req;
    logic [31:0] Mem_addr;
    logic        Mem_done = 1'b0;
    logic [31:0] Mem_inst = '0;

    int n_checks = 0;
    int n_fail   = 0;

    bit mem_hold = 1'b0;
    bit mem_fire = 1'b0;
    bit mem_rand = 1'b0;
    int mem_lat  = 3;
    int remaining = -1;

    always #5 clk = ~clk;

    inst_fetch #(
        .ICACHE_IDX_W (6)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rdy      (rdy),
        .roll     (roll),
        .roll_PC  (roll_PC),
        .IQ_full  (IQ_full),
        .IF_flag  (IF_flag),
        .IF_inst  (IF_inst),
        .IF_PC    (IF_PC),
        .Mem_req  (Mem_req),
        .Mem_addr (Mem_addr),
        .Mem_done (Mem_done),
        .Mem_inst (Mem_inst)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h0000_0013;
    endfunction

    // Memory controller model; in hold mode the test picks the done cycle.
    always @(negedge clk) begin
        Mem_done = 1'b0;
        if (rst || !Mem_req) begin
            remaining = -1;
        end else if (mem_hold) begin
            if (mem_fire) begin
                Mem_done  = 1'b1;
                Mem_inst  = mem_word(Mem_addr);
                remaining = -1;
            end
        end else if (rdy) begin
            if (remaining < 0)
                remaining = mem_rand ? int'($urandom_range(1, 4)) : mem_lat;
            remaining--;
            if (remaining == 0) begin
                Mem_done  = 1'b1;
                Mem_inst  = mem_word(Mem_addr);
                remaining = -1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input int max, output bit ok, output int cyc);
        ok = 1'b0;
        cyc = 0;
        for (int i = 0; i < max; i++) begin
            if (Mem_req) begin
                ok = 1'b1;
                break;
            end
            tick();
            cyc++;
        end
        if (!ok && Mem_req) ok = 1'b1;
    endtask

    task automatic wait_flag(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            if (IF_flag) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok && IF_flag) ok = 1'b1;
    endtask

    task automatic do_reset(input logic full);
        rst = 1'b1;
        rdy = 1'b1;
        roll = 1'b0;
        roll_PC = '0;
        IQ_full = full;
        mem_hold = 1'b0;
        mem_fire = 1'b0;
        mem_rand = 1'b0;
        mem_lat = 3;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(1'b0);
        n_checks++;
        if ({IF_flag, Mem_req} !== 2'b00 || IF_PC !== 0
            || IF_inst !== 0 || Mem_addr !== 0) begin
            n_fail++;
            $display("FAIL reset: flag=%b req=%b pc=%h inst=%h addr=%h want all 0",
                     IF_flag, Mem_req, IF_PC, IF_inst, Mem_addr);
        end
    endtask

    task automatic test_first_fetch();
        bit ok;
        int cyc;
        do_reset(1'b0);
        wait_req(10, ok, cyc);
        n_checks++;
        if (!ok || Mem_addr !== 32'h0 || cyc !== 1) begin
            n_fail++;
            $display("FAIL first_req: ok=%b addr=%h cyc=%0d want addr 0 cyc 1",
                     ok, Mem_addr, cyc);
        end
        wait_flag(10, ok);
        n_checks++;
        if (!ok || IF_PC !== 32'h0 || IF_inst !== 32'h13) begin
            n_fail++;
            $display("FAIL first_push: ok=%b pc=%h inst=%h want 0/00000013",
                     ok, IF_PC, IF_inst);
        end
        tick();
        n_checks++;
        if (IF_flag !== 1'b0) begin
            n_fail++;
            $display("FAIL flag_pulse: flag=%b want 0", IF_flag);
        end
        wait_req(10, ok, cyc);
        n_checks++;
        if (!ok || Mem_addr !== 32'h4) begin
            n_fail++;
            $display("FAIL second_req: ok=%b addr=%h want 4", ok, Mem_addr);
        end
    endtask

    task automatic test_iq_full();
        bit ok;
        int cyc;
        int bad = 0;
        do_reset(1'b1);
        for (int i = 0; i < 8; i++) begin
            tick();
            if (Mem_req || IF_flag) bad++;
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL iq_full_hold: active cycles=%0d want 0", bad);
        end
        IQ_full = 1'b0;
        wait_req(10, ok, cyc);
        n_checks++;
        if (!ok || Mem_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL iq_full_pc: ok=%b addr=%h want 0", ok, Mem_addr);
        end
    endtask

    task automatic test_roll_wait();
        bit ok;
        int cyc;
        int bad = 0;
        do_reset(1'b0);
        mem_lat = 2;
        wait_flag(20, ok);
        tick();
        wait_flag(20, ok);
        mem_hold = 1'b1;
        wait_req(10, ok, cyc);
        n_checks++;
        if (!ok || Mem_addr !== 32'h8) begin
            n_fail++;
            $display("FAIL roll_wait_req: ok=%b addr=%h want 8", ok, Mem_addr);
        end
        roll = 1'b1;
        roll_PC = 32'h100;
        tick();
        roll = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (Mem_req !== 1'b1 || IF_flag !== 1'b0) bad++;
            tick();
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL roll_wait_hold: bad cycles=%0d want 0", bad);
        end
        mem_fire = 1'b1;
        tick();
        mem_fire = 1'b0;
        n_checks++;
        if (Mem_req !== 1'b0 || IF_flag !== 1'b0) begin
            n_fail++;
            $display("FAIL roll_wait_drop: req=%b flag=%b want 0/0",
                     Mem_req, IF_flag);
        end
        mem_hold = 1'b0;
        wait_req(10, ok, cyc);
        n_checks++;
        if (!ok || Mem_addr !== 32'h100) begin
            n_fail++;
            $display("FAIL roll_wait_target: addr=%h want 00000100", Mem_addr);
        end
        wait_flag(10, ok);
        n_checks++;
        if (!ok || IF_PC !== 32'h100 || IF_inst !== mem_word(32'h100)) begin
            n_fail++;
            $display("FAIL roll_wait_push: pc=%h inst=%h want 100/%h",
                     IF_PC, IF_inst, mem_word(32'h100));
        end
    endtask

    task automatic test_roll_done();
        bit ok;
        int cyc;
        do_reset(1'b0);
        mem_hold = 1'b1;
        wait_req(10, ok, cyc);
        roll = 1'b1;
        roll_PC = 32'h200;
        mem_fire = 1'b1;
        tick();
        roll = 1'b0;
        mem_fire = 1'b0;
        n_checks++;
        if (IF_flag !== 1'b0 || Mem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL roll_done: flag=%b req=%b want 0/0",
                     IF_flag, Mem_req);
        end
        tick();
        n_checks++;
        if (Mem_req !== 1'b1 || Mem_addr !== 32'h200) begin
            n_fail++;
            $display("FAIL roll_done_next: req=%b addr=%h want 1/200",
                     Mem_req, Mem_addr);
        end
        mem_hold = 1'b0;
        wait_flag(10, ok);
        n_checks++;
        if (!ok || IF_PC !== 32'h200) begin
            n_fail++;
            $display("FAIL roll_done_push: pc=%h want 200", IF_PC);
        end
    endtask

    task automatic test_rdy_freeze();
        bit ok;
        int cyc;
        int bad = 0;
        logic [97:0] snap;
        do_reset(1'b0);
        mem_hold = 1'b1;
        wait_req(10, ok, cyc);
        tick();
        snap = {IF_flag, Mem_req, IF_inst, IF_PC, Mem_addr};
        rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            mem_fire = (i == 2);
            tick();
            if ({IF_flag, Mem_req, IF_inst, IF_PC, Mem_addr} !== snap) bad++;
        end
        mem_fire = 1'b0;
        rdy = 1'b1;
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL freeze_wait: changed cycles=%0d want 0", bad);
        end
        mem_fire = 1'b1;
        tick();
        mem_fire = 1'b0;
        n_checks++;
        if (IF_flag !== 1'b1 || IF_PC !== 32'h0 || IF_inst !== 32'h13) begin
            n_fail++;
            $display("FAIL freeze_resume: flag=%b pc=%h inst=%h want 1/0/13",
                     IF_flag, IF_PC, IF_inst);
        end
        snap = {IF_flag, Mem_req, IF_inst, IF_PC, Mem_addr};
        rdy = 1'b0;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if ({IF_flag, Mem_req, IF_inst, IF_PC, Mem_addr} !== snap) bad++;
        end
        rdy = 1'b1;
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL freeze_flag: changed cycles=%0d want 0", bad);
        end
        tick();
        n_checks++;
        if (IF_flag !== 1'b0 || Mem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL freeze_after: flag=%b req=%b want 0/0",
                     IF_flag, Mem_req);
        end
        tick();
        n_checks++;
        if (Mem_req !== 1'b1 || Mem_addr !== 32'h4) begin
            n_fail++;
            $display("FAIL freeze_next: req=%b addr=%h want 1/4",
                     Mem_req, Mem_addr);
        end
    endtask

`ifdef ICACHE_EN
    task automatic test_cache();
        bit ok;
        int cyc;
        int reqs = 0;
        int pushes = 0;
        int bad = 0;
        logic [31:0] exp_pc;
        do_reset(1'b0);
        mem_lat = 2;
        for (int k = 0; k < 4; k++) begin
            wait_flag(20, ok);
            if (!ok || IF_PC !== 32'(k * 4)) bad++;
            if (k == 3) mem_hold = 1'b1;
            tick();
        end
        wait_req(10, ok, cyc);
        roll = 1'b1;
        roll_PC = 32'h0;
        tick();
        roll = 1'b0;
        mem_fire = 1'b1;
        tick();
        mem_fire = 1'b0;
        mem_hold = 1'b0;
        exp_pc = 32'h0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (Mem_req) reqs++;
            if (IF_flag !== ((i % 2) == 1)) bad++;
            if (IF_flag) begin
                pushes++;
                if (IF_PC !== exp_pc || IF_inst !== mem_word(exp_pc)) bad++;
                exp_pc += 4;
            end
        end
        n_checks++;
        if (reqs !== 0 || pushes !== 4 || bad !== 0) begin
            n_fail++;
            $display("FAIL cache_hits: reqs=%0d pushes=%0d bad=%0d want 0/4/0",
                     reqs, pushes, bad);
        end
        roll = 1'b1;
        roll_PC = 32'h100;
        tick();
        roll = 1'b0;
        wait_req(10, ok, cyc);
        n_checks++;
        if (!ok || Mem_addr !== 32'h100) begin
            n_fail++;
            $display("FAIL cache_alias: ok=%b addr=%h want miss at 100",
                     ok, Mem_addr);
        end
    endtask
`endif

    task automatic test_random();
        logic [31:0] model_pc = 32'h0;
        int qcount = 0;
        int npush = 0;
        bit p_rdy = 1'b1;
        bit p_roll = 1'b0;
        bit p_pop = 1'b0;
        logic [31:0] p_rpc = '0;
        logic o_flag = 1'b0;
        logic o_req = 1'b0;
        logic [31:0] o_addr = '0;
        logic [97:0] snap = '0;
        do_reset(1'b0);
        mem_rand = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if (c > 0) begin
                if (!p_rdy) begin
                    n_checks++;
                    if ({IF_flag, Mem_req, IF_inst, IF_PC, Mem_addr} !== snap) begin
                        n_fail++;
                        $display("FAIL rand_freeze c=%0d: outputs changed", c);
                    end
                end else begin
                    n_checks++;
                    if (o_flag && qcount >= CAP) begin
                        n_fail++;
                        $display("FAIL rand_overflow c=%0d: push with %0d/%0d",
                                 c, qcount, CAP);
                    end else if (o_flag) begin
                        qcount++;
                    end
                    if (p_pop && qcount > 0) qcount--;
                    n_checks++;
                    if (o_flag && IF_flag) begin
                        n_fail++;
                        $display("FAIL rand_b2b c=%0d: back-to-back push", c);
                    end
                    if (p_roll) begin
                        n_checks++;
                        if (IF_flag !== 1'b0) begin
                            n_fail++;
                            $display("FAIL rand_roll c=%0d: flag=%b want 0",
                                     c, IF_flag);
                        end
                        model_pc = p_rpc;
                    end else if (IF_flag) begin
                        n_checks++;
                        if (IF_PC !== model_pc || IF_inst !== mem_word(model_pc)) begin
                            n_fail++;
                            $display("FAIL rand_push c=%0d: pc=%h inst=%h want %h/%h",
                                     c, IF_PC, IF_inst, model_pc, mem_word(model_pc));
                        end
                        model_pc += 4;
                        npush++;
                    end
                    if (Mem_req && !o_req) begin
                        n_checks++;
                        if (Mem_addr !== model_pc) begin
                            n_fail++;
                            $display("FAIL rand_addr c=%0d: addr=%h want %h",
                                     c, Mem_addr, model_pc);
                        end
                    end else if (Mem_req && o_req) begin
                        n_checks++;
                        if (Mem_addr !== o_addr) begin
                            n_fail++;
                            $display("FAIL rand_stable c=%0d: addr=%h want %h",
                                     c, Mem_addr, o_addr);
                        end
                    end
                end
            end
            snap = {IF_flag, Mem_req, IF_inst, IF_PC, Mem_addr};
            o_flag = IF_flag;
            o_req = Mem_req;
            o_addr = Mem_addr;
            IQ_full = (qcount >= CAP);
            p_rdy = ($urandom_range(0, 7) != 0);
            p_roll = ($urandom_range(0, 23) == 0);
            p_rpc = ($urandom_range(0, 3) == 0)
                  ? 32'hFFFF_FFF0
                  : {$urandom_range(0, 255), 2'b00};
            p_pop = (qcount > 0) && ($urandom_range(0, 2) != 0);
            rdy = p_rdy;
            roll = p_roll;
            roll_PC = p_rpc;
            tick();
        end
        rdy = 1'b1;
        roll = 1'b0;
        n_checks++;
        if (npush < 100) begin
            n_fail++;
            $display("FAIL rand_progress: pushes=%0d want >=100", npush);
        end
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_iq_full();
        test_roll_wait();
        test_roll_done();
        test_rdy_freeze();
`ifdef ICACHE_EN
        test_cache();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
